// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU sequencer/arbiter.
// FSM states, ALU op codes and default datapath widths.
package alu_seq_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_RES_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

endpackage

// File: rtl/alu_seq_arb_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic, purely combinational.
// On contention the requester that did not win last time is granted.
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    input  logic       i_en,
    output logic       o_grant_vld,
    output logic       o_grant_id,
    output logic [1:0] o_ready
);

    logic w_id;

    always_comb begin
        w_id = 1'b0;
        unique case (i_valid)
            2'b01:   w_id = 1'b0;
            2'b10:   w_id = 1'b1;
            2'b11:   w_id = ~i_last_grant;
            default: w_id = 1'b0;
        endcase
    end

    assign o_grant_vld = i_en && (|i_valid);
    assign o_grant_id  = w_id;
    assign o_ready[0]  = o_grant_vld && !w_id;
    assign o_ready[1]  = o_grant_vld && w_id;

endmodule

// File: rtl/alu_seq_arb.sv
// alu_seq_arb: sequences requests from two ports onto one shared ALU.
// Define ALU_SEQ_DIV0_FLAG_EN to flag divide-by-zero on rsp_err.
module alu_seq_arb
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int RES_W  = DEF_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_err
);

    state_t              r_state;
    logic                r_last_grant;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_sel;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [RES_W-1:0]    r_rsp_data;

    logic                w_grant_vld;
    logic                w_grant_id;
    logic [1:0]          w_ready;
    logic [OP_W-1:0]     w_op;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_rsp_hs;

    rr_arb2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_en         (r_state == IDLE),
        .o_grant_vld  (w_grant_vld),
        .o_grant_id   (w_grant_id),
        .o_ready      (w_ready)
    );

    assign w_op     = w_grant_id ? req1_op : req0_op;
    assign w_a      = w_grant_id ? req1_a  : req0_a;
    assign w_b      = w_grant_id ? req1_b  : req0_b;
    assign w_rsp_hs = r_rsp_valid && rsp_ready;

    // Ready equals grant, so a grant in IDLE is always a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_alu_sel    <= w_op;
                        r_alu_a      <= w_a;
                        r_alu_b      <= w_b;
                        r_rsp_id     <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= alu_result;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_DIV0_FLAG_EN
    logic r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_err <= (r_alu_sel == OP_W'(OP_DIV)) && (r_alu_b == '0);
        end else if (r_state == RESP && w_rsp_hs) begin
            r_rsp_err <= 1'b0;
        end
    end

    assign rsp_err = r_rsp_err;
`else
    assign rsp_err = 1'b0;
`endif

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

endmodule
